// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Default register-address width used by the datapath.
  localparam int REG_W_DEFAULT = 5;

  // Register 0 is hard-wired to zero and never creates a dependency.
  localparam int unsigned REG_ZERO = 0;

  // Sequencer states: normal running, or waiting on a multi-cycle SRAM access.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard/control bundle between the pipeline datapath and the controller.
import pipe_ctrl_pkg::*;

interface pipeline_hazard_controller_if #(
  parameter int REG_W = REG_W_DEFAULT,
  parameter int CNT_W = 16
);

  // Pipeline state observed by the controller
  logic             forward_en;
  logic [REG_W-1:0] src1_ID;
  logic [REG_W-1:0] src2_ID;
  logic             is_two_source_ID;
  logic [REG_W-1:0] dest_EXE;
  logic             WB_EN_EXE;
  logic             MEM_R_EN_EXE;
  logic [REG_W-1:0] dest_MEM;
  logic             WB_EN_MEM;
  logic             branch_taken_EXE;
  logic             mem_req_MEM;
  logic             sram_ready;

  // Sequencing decisions and status produced by the controller
  logic             sram_start;
  logic             freeze_all;
  logic             freeze_IF;
  logic             bubble_ID_EXE;
  logic             flush_IF_ID;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout_err;

  // Datapath side: supplies pipeline state, consumes control.
  modport master (
    output forward_en, src1_ID, src2_ID, is_two_source_ID,
           dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, dest_MEM, WB_EN_MEM,
           branch_taken_EXE, mem_req_MEM, sram_ready,
    input  sram_start, freeze_all, freeze_IF, bubble_ID_EXE, flush_IF_ID,
           stall_cycles, flush_count, mem_timeout_err
  );

  // Controller side.
  modport slave (
    input  forward_en, src1_ID, src2_ID, is_two_source_ID,
           dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, dest_MEM, WB_EN_MEM,
           branch_taken_EXE, mem_req_MEM, sram_ready,
    output sram_start, freeze_all, freeze_IF, bubble_ID_EXE, flush_IF_ID,
           stall_cycles, flush_count, mem_timeout_err
  );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Count qualifying cycles, holding once the maximum is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/bubble/flush sequencer for the 5-stage pipeline, including
// the SRAM start/ready handshake with whole-pipeline freeze.
import pipe_ctrl_pkg::*;

module pipeline_hazard_controller #(
  parameter int REG_W       = REG_W_DEFAULT,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input logic                          clk,
  input logic                          rst,
  pipeline_hazard_controller_if.slave  bus
);

  // Wait counter only needs to reach MEM_TIMEOUT-1; it parks there afterwards.
  localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [REG_W-1:0]  ZERO_REG  = REG_W'(REG_ZERO);

  ctrl_state_e       state_r;
  ctrl_state_e       next_state_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              timeout_err_r;

  logic match_exe_s;
  logic match_mem_s;
  logic hazard_s;

  logic sram_start_s;
  logic freeze_all_s;
  logic freeze_if_s;
  logic bubble_s;
  logic flush_s;
  logic stall_inc_s;

  // Does the ID instruction read the EXE / MEM destinations (r0 excluded)?
  always_comb begin
    match_exe_s = 1'b0;
    match_mem_s = 1'b0;
    if (bus.dest_EXE != ZERO_REG) begin
      match_exe_s = (bus.src1_ID == bus.dest_EXE) |
                    (bus.is_two_source_ID & (bus.src2_ID == bus.dest_EXE));
    end else begin
      match_exe_s = 1'b0;
    end
    if (bus.dest_MEM != ZERO_REG) begin
      match_mem_s = (bus.src1_ID == bus.dest_MEM) |
                    (bus.is_two_source_ID & (bus.src2_ID == bus.dest_MEM));
    end else begin
      match_mem_s = 1'b0;
    end
  end

  // With forwarding only a load in EXE must stall; without it any pending write does.
  always_comb begin
    hazard_s = 1'b0;
    if (bus.forward_en) begin
      hazard_s = bus.MEM_R_EN_EXE & bus.WB_EN_EXE & match_exe_s;
    end else begin
      hazard_s = (bus.WB_EN_EXE & match_exe_s) | (bus.WB_EN_MEM & match_mem_s);
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state: ready is only honoured once we are actually waiting.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RUN: begin
        if (bus.mem_req_MEM) begin
          next_state_s = MEM_WAIT;
        end else begin
          next_state_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (bus.sram_ready) begin
          next_state_s = RUN;
        end else begin
          next_state_s = MEM_WAIT;
        end
      end
      default: next_state_s = RUN;
    endcase
  end

  // Control outputs: SRAM freeze dominates, then branch kill, then data hazard.
  always_comb begin
    sram_start_s = 1'b0;
    freeze_all_s = 1'b0;
    freeze_if_s  = 1'b0;
    bubble_s     = 1'b0;
    flush_s      = 1'b0;
    if (rst) begin
      sram_start_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          sram_start_s = bus.mem_req_MEM;
          freeze_all_s = bus.mem_req_MEM;
        end
        MEM_WAIT: begin
          sram_start_s = 1'b0;
          freeze_all_s = ~bus.sram_ready;
        end
        default: begin
          sram_start_s = 1'b0;
          freeze_all_s = 1'b0;
        end
      endcase

      if (freeze_all_s) begin
        // Everything is held; a pending branch is serviced after release.
        freeze_if_s = 1'b0;
      end else if (bus.branch_taken_EXE) begin
        flush_s  = 1'b1;
        bubble_s = 1'b1;
      end else if (hazard_s) begin
        freeze_if_s = 1'b1;
        bubble_s    = 1'b1;
      end else begin
        freeze_if_s = 1'b0;
      end
    end
  end

  // Track SRAM wait length and latch a sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r    <= {WAIT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else if ((state_r == MEM_WAIT) && !bus.sram_ready) begin
      if (wait_cnt_r == WAIT_LAST) begin
        timeout_err_r <= 1'b1;
        wait_cnt_r    <= wait_cnt_r;
      end else begin
        timeout_err_r <= timeout_err_r;
        wait_cnt_r    <= wait_cnt_r + WAIT_W'(1);
      end
    end else begin
      wait_cnt_r    <= {WAIT_W{1'b0}};
      timeout_err_r <= timeout_err_r;
    end
  end

  assign stall_inc_s = freeze_if_s | freeze_all_s;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc_s),
    .count (bus.stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_s),
    .count (bus.flush_count)
  );

  assign bus.sram_start      = sram_start_s;
  assign bus.freeze_all      = freeze_all_s;
  assign bus.freeze_IF       = freeze_if_s;
  assign bus.bubble_ID_EXE   = bubble_s;
  assign bus.flush_IF_ID     = flush_s;
  assign bus.mem_timeout_err = timeout_err_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the controller.
module tb_pipeline_hazard_controller;

  localparam int REG_W       = 5;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  pipeline_hazard_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_controller #(
    .REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model state: is an SRAM access outstanding, and for how long.
  bit m_busy;
  int m_waited;
  bit m_err;
  int m_stall;
  int m_flush;
  // Expected combinational outputs for the current cycle.
  bit e_start, e_fa, e_fif, e_bub, e_fl;
  // Observed combinational outputs for directed spot checks.
  bit o_start, o_fa, o_fif, o_bub, o_fl;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit id_reads(input logic [REG_W-1:0] d);
    if (d == 0) return 1'b0;
    return (bus.src1_ID == d) || (bus.is_two_source_ID && bus.src2_ID == d);
  endfunction

  task automatic model_comb();
    bit haz;
    e_start = 0; e_fa = 0; e_fif = 0; e_bub = 0; e_fl = 0;
    if (rst) begin
      m_busy = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (bus.forward_en)
      haz = bus.MEM_R_EN_EXE && bus.WB_EN_EXE && id_reads(bus.dest_EXE);
    else
      haz = (bus.WB_EN_EXE && id_reads(bus.dest_EXE)) ||
            (bus.WB_EN_MEM && id_reads(bus.dest_MEM));
    e_start = !m_busy && bus.mem_req_MEM;
    e_fa    = m_busy ? !bus.sram_ready : bus.mem_req_MEM;
    if (!e_fa) begin
      e_fl  = bus.branch_taken_EXE;
      e_fif = !bus.branch_taken_EXE && haz;
      e_bub = bus.branch_taken_EXE || haz;
    end
  endtask

  task automatic model_seq();
    if (rst) return;
    if (e_fif || e_fa) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
    if (e_fl)          m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
    if (!m_busy) begin
      m_busy   = bus.mem_req_MEM;
      m_waited = 0;
    end else begin
      m_waited++;
      if (bus.sram_ready) begin
        m_busy   = 0;
        m_waited = 0;
      end else if (m_waited >= MEM_TIMEOUT) begin
        m_err = 1;
      end
    end
  endtask

  // One clock cycle: inputs were applied at the preceding negedge.
  task automatic step();
    #1;
    model_comb();
    o_start = bus.sram_start; o_fa = bus.freeze_all; o_fif = bus.freeze_IF;
    o_bub = bus.bubble_ID_EXE; o_fl = bus.flush_IF_ID;
    check_val("sram_start", 32'(o_start), 32'(e_start));
    check_val("freeze_all", 32'(o_fa), 32'(e_fa));
    check_val("freeze_IF", 32'(o_fif), 32'(e_fif));
    check_val("bubble", 32'(o_bub), 32'(e_bub));
    check_val("flush", 32'(o_fl), 32'(e_fl));
    if (rst) begin
      check_val("rst_stall_cnt", 32'(bus.stall_cycles), 32'd0);
      check_val("rst_flush_cnt", 32'(bus.flush_count), 32'd0);
      check_val("rst_err", 32'(bus.mem_timeout_err), 32'd0);
    end
    @(posedge clk);
    #1;
    model_seq();
    check_val("stall_cycles", 32'(bus.stall_cycles), 32'(m_stall));
    check_val("flush_count", 32'(bus.flush_count), 32'(m_flush));
    check_val("timeout_err", 32'(bus.mem_timeout_err), 32'(m_err));
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.forward_en = 0; bus.src1_ID = '0; bus.src2_ID = '0; bus.is_two_source_ID = 0;
    bus.dest_EXE = '0; bus.WB_EN_EXE = 0; bus.MEM_R_EN_EXE = 0;
    bus.dest_MEM = '0; bus.WB_EN_MEM = 0; bus.branch_taken_EXE = 0;
    bus.mem_req_MEM = 0; bus.sram_ready = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1; step();
    rst = 0;
  endtask

  task automatic load_use(input logic [REG_W-1:0] d);
    set_idle();
    bus.forward_en = 1; bus.MEM_R_EN_EXE = 1; bus.WB_EN_EXE = 1;
    bus.dest_EXE = d; bus.src1_ID = 5'd3;
  endtask

  int n_start, n_fa;

  initial begin
    total = 0; bad = 0;
    m_busy = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
    set_idle();
    rst = 1;
    @(negedge clk);
    step();
    rst = 0;

    // Load-use with forwarding, then the same against r0.
    load_use(5'd3); step();
    check_val("lu_fif", 32'(o_fif), 32'd1);
    check_val("lu_bub", 32'(o_bub), 32'd1);
    check_val("lu_stall", 32'(bus.stall_cycles), 32'd1);
    load_use(5'd0); step();
    check_val("lu_r0_fif", 32'(o_fif), 32'd0);

    // No forwarding: MEM-stage producer on src2.
    set_idle(); bus.WB_EN_MEM = 1; bus.dest_MEM = 5'd7; bus.src1_ID = 5'd1; bus.src2_ID = 5'd7;
    bus.is_two_source_ID = 1; step();
    check_val("nf_two_fif", 32'(o_fif), 32'd1);
    bus.is_two_source_ID = 0; step();
    check_val("nf_one_fif", 32'(o_fif), 32'd0);
    bus.is_two_source_ID = 1; bus.forward_en = 1; step();
    check_val("fwd_mem_fif", 32'(o_fif), 32'd0);

    // SRAM handshake: ready four cycles after start.
    do_reset();
    n_start = 0; n_fa = 0;
    bus.mem_req_MEM = 1;
    for (int i = 0; i < 5; i++) begin
      bus.sram_ready = (i == 4);
      step();
      n_start += int'(o_start);
      n_fa    += int'(o_fa);
    end
    check_val("sram_start_cycles", 32'(n_start), 32'd1);
    check_val("sram_freeze_cycles", 32'(n_fa), 32'd4);
    check_val("sram_ready_fa", 32'(o_fa), 32'd0);
    check_val("sram_stall", 32'(bus.stall_cycles), 32'd4);
    set_idle(); step();
    check_val("sram_back_run", 32'(o_fa), 32'd0);

    // Branch beats load-use; branch held during freeze waits for release.
    do_reset();
    load_use(5'd3); bus.branch_taken_EXE = 1; step();
    check_val("br_fl", 32'(o_fl), 32'd1);
    check_val("br_bub", 32'(o_bub), 32'd1);
    check_val("br_fif", 32'(o_fif), 32'd0);
    check_val("br_cnt", 32'(bus.flush_count), 32'd1);
    set_idle(); bus.branch_taken_EXE = 1; bus.mem_req_MEM = 1; step();
    check_val("br_frz_fl0", 32'(o_fl), 32'd0);
    bus.mem_req_MEM = 0; step();
    check_val("br_frz_fl1", 32'(o_fl), 32'd0);
    bus.sram_ready = 1; step();
    check_val("br_release_fl", 32'(o_fl), 32'd1);

    // Timeout: ready withheld for more than MEM_TIMEOUT wait cycles.
    do_reset();
    bus.mem_req_MEM = 1; step();
    bus.mem_req_MEM = 0;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step();
    check_val("to_before", 32'(bus.mem_timeout_err), 32'd0);
    step();
    check_val("to_set", 32'(bus.mem_timeout_err), 32'd1);
    for (int i = 0; i < 3; i++) step();
    check_val("to_still_frozen", 32'(o_fa), 32'd1);
    bus.sram_ready = 1; step();
    check_val("to_ready_fa", 32'(o_fa), 32'd0);
    bus.sram_ready = 0; step();
    check_val("to_sticky", 32'(bus.mem_timeout_err), 32'd1);

    // Asynchronous reset in the middle of a wait.
    bus.mem_req_MEM = 1; step();
    bus.mem_req_MEM = 0; step(); step();
    bus.mem_req_MEM = 1; rst = 1; step();
    check_val("arst_start", 32'(o_start), 32'd0);
    rst = 0; bus.mem_req_MEM = 0; step();
    check_val("arst_run", 32'(o_fa), 32'd0);

    // Saturation of the stall counter.
    do_reset();
    load_use(5'd3);
    for (int i = 0; i < 20; i++) step();
    check_val("sat_stall", 32'(bus.stall_cycles), 32'(CNT_MAX));

    // Randomized traffic against the model.
    set_idle();
    for (int n = 0; n < 600; n++) begin
      bus.forward_en       = 1'($urandom_range(0, 1));
      bus.src1_ID          = REG_W'($urandom_range(0, 3));
      bus.src2_ID          = REG_W'($urandom_range(0, 3));
      bus.is_two_source_ID = 1'($urandom_range(0, 1));
      bus.dest_EXE         = REG_W'($urandom_range(0, 3));
      bus.WB_EN_EXE        = 1'($urandom_range(0, 1));
      bus.MEM_R_EN_EXE     = 1'($urandom_range(0, 1));
      bus.dest_MEM         = REG_W'($urandom_range(0, 3));
      bus.WB_EN_MEM        = 1'($urandom_range(0, 1));
      bus.branch_taken_EXE = ($urandom_range(0, 5) == 0);
      bus.mem_req_MEM      = ($urandom_range(0, 4) == 0);
      bus.sram_ready       = ($urandom_range(0, 5) == 0);
      rst                  = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central sequencing block for the 5-stage pipeline; decides each cycle whether stages advance, hold, take a bubble or get flushed. Detects load-use and data hazards in ID against EXE/MEM destinations. The hazard rules depend on whether register forwarding is enabled. Also sequences the multi-cycle SRAM access from the MEM stage (start/ready handshake with a whole-pipeline freeze) and keeps saturating performance counters plus a sticky timeout flag.

Parameters:
REG_W, 5, register-address width of all src/dest fields
CNT_W, 16, width of the performance counters
MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout_err sets (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
forward_en  input  1  1 = forwarding enabled in the datapath
src1_ID  input  REG_W  first source register of the ID instruction
src2_ID  input  REG_W  second source register of the ID instruction
is_two_source_ID  input  1  ID instruction uses src2_ID
dest_EXE  input  REG_W  destination register of the EXE instruction
WB_EN_EXE  input  1  EXE instruction writes back
MEM_R_EN_EXE  input  1  EXE instruction is a load
dest_MEM  input  REG_W  destination register of the MEM instruction
WB_EN_MEM  input  1  MEM instruction writes back
branch_taken_EXE  input  1  branch resolved taken in EXE
mem_req_MEM  input  1  MEM instruction is a load or store
sram_ready  input  1  SRAM access complete (1-cycle pulse)
sram_start  output  1  start SRAM access
freeze_all  output  1  hold IF/ID, ID/EXE, EXE/MEM and MEM/WB registers and PC
freeze_IF  output  1  hold PC and the IF/ID register
bubble_ID_EXE  output  1  load a NOP into the ID/EXE register
flush_IF_ID  output  1  clear the IF/ID register
stall_cycles  output  CNT_W  count of cycles with freeze_IF or freeze_all
flush_count  output  CNT_W  count of cycles with flush_IF_ID
mem_timeout_err  output  1  sticky: an SRAM wait exceeded MEM_TIMEOUT

Behaviour:
- FSM states: RUN, MEM_WAIT. Reset -> RUN, wait_cnt=0, both counters 0, mem_timeout_err 0. Reset mid-wait aborts to RUN.
- Register 0 never causes a hazard: any match against dest==0 is ignored.
- match(d) = (src1_ID==d) | (is_two_source_ID & src2_ID==d), with d != 0.
- forward_en=1: hazard = MEM_R_EN_EXE & WB_EN_EXE & match(dest_EXE). This is the load-use case only.
- forward_en=0: hazard = (WB_EN_EXE & match(dest_EXE)) | (WB_EN_MEM & match(dest_MEM)).
- RUN with mem_req_MEM=1:
  - sram_start=1 and freeze_all=1 for this cycle (combinational).
  - Next state MEM_WAIT. sram_ready is ignored in RUN, so the minimum latency is one wait cycle.
- MEM_WAIT:
  - sram_start=0.
  - freeze_all = ~sram_ready. The cycle in which ready is seen lets the pipeline advance, and the FSM returns to RUN.
  - wait_cnt increments each cycle in MEM_WAIT and clears on leaving it.
  - When wait_cnt reaches MEM_TIMEOUT-1 without ready, mem_timeout_err sets and stays set until reset. The FSM keeps waiting.
- Priority, evaluated each cycle:
  1. freeze_all=1: freeze_IF=0, bubble_ID_EXE=0, flush_IF_ID=0. The branch stays held in EXE and is acted on once the freeze releases.
  2. branch_taken_EXE=1: flush_IF_ID=1, bubble_ID_EXE=1, freeze_IF=0. Any hazard is suppressed because the ID instruction is being killed.
  3. hazard=1: freeze_IF=1, bubble_ID_EXE=1, flush_IF_ID=0.
  4. Otherwise all control outputs are 0.
- All control outputs are combinational from the inputs and state; all are 0 during reset.
- Counters:
  - Registered, saturating at all-ones with no wrap.
  - stall_cycles increments when (freeze_IF | freeze_all).
  - flush_count increments when flush_IF_ID.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - the state enum {RUN, MEM_WAIT}
  - REG_W default
  - the REG_ZERO constant
- One natural sub-module, sat_counter (CNT_W, inc, clk, rst), instanced twice.
- Hazard compare logic stays inline.

Test Plan:
- Load-use with forwarding: forward_en=1, MEM_R_EN_EXE=1, WB_EN_EXE=1, dest_EXE=3, src1_ID=3 -> freeze_IF=1 and bubble_ID_EXE=1 for 1 cycle; stall_cycles 0->1. Same stimulus with dest_EXE=0 -> no stall.
- No forwarding: forward_en=0, WB_EN_MEM=1, dest_MEM=7, src2_ID=7:
  - is_two_source_ID=1 -> stall.
  - is_two_source_ID=0 -> no stall.
  - forward_en=1 with the same match -> no stall.
- SRAM sequence: mem_req_MEM=1 held, sram_ready pulses 4 cycles after sram_start -> sram_start high exactly 1 cycle; freeze_all high 4 cycles and low in the ready cycle; state back to RUN; stall_cycles=4.
- Simultaneous events: branch_taken_EXE=1 and load-use hazard together -> flush_IF_ID=1, bubble_ID_EXE=1, freeze_IF=0; flush_count=1. The same branch during freeze_all -> no flush until the freeze releases.
- Timeout: MEM_TIMEOUT=8, sram_ready withheld -> mem_timeout_err rises after the 8th MEM_WAIT cycle and stays 1 after a later ready; freeze_all stays 1 until that ready.
- Async reset mid-MEM_WAIT and saturation:
  - rst asserted mid-wait -> outputs 0 immediately, state RUN, counters 0.
  - CNT_W=4 with 20 stall cycles -> stall_cycles=15.
